// File: rtl/wired_icache_refill.sv
// I-cache fetch-miss responder: turns refill/uncached requests into one read burst, fills the SRAMs on refill.
// Latency: accept -> ADDR (1 cycle), burst, then a one-cycle resp_ready_o pulse; at least one IDLE cycle between requests.
// Backpressure: mem_ar_valid_o held until mem_ar_ready_i; beats accepted only in DATA; req held by initiator until the pulse.
module wired_icache_refill #(
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  input  logic [31:0]              req_paddr_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_alloc_i,
  input  logic                     req_unc_i,
  output logic                     resp_ready_o,
  output logic [63:0]              resp_rdata_o,
  output logic                     mem_ar_valid_o,
  input  logic                     mem_ar_ready_i,
  output logic [31:0]              mem_ar_addr_o,
  output logic [7:0]               mem_ar_len_o,
  output logic [2:0]               mem_ar_size_o,
  input  logic                     mem_r_valid_i,
  output logic                     mem_r_ready_o,
  input  logic [31:0]              mem_r_data_i,
  input  logic                     mem_r_last_i,
  output logic [11:0]              snoop_daddr_o,
  output logic [1:0]               snoop_dway_o,
  output logic [LINE_WORDS*32-1:0] snoop_d_o,
  output logic                     snoop_dwe_o,
  output logic [11:0]              snoop_taddr_o,
  output logic [WAYS-1:0]          snoop_twe_o,
  output logic [20:0]              snoop_t_o
);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                       state_q;
  logic [31:2]                  paddr_q;
  logic [1:0]                   size_q;
  logic                         alloc_q;
  logic [WW-1:0]                way_q;
  logic [BW-1:0]                beat_q;
  logic [LINE_WORDS-1:0][31:0]  line_q;
  logic                         ar_vld_q;
  logic [31:0]                  ar_addr_q;
  logic [7:0]                   ar_len_q;
  logic                         r_rdy_q;
  logic                         resp_q;
  logic                         dwe_q;
  logic [WAYS-1:0]              twe_q;

  logic [31:0]                  ar_addr_d;
  logic [7:0]                   ar_len_d;
  logic [WW-1:0]                way_d;
  logic [WAYS-1:0]              twe_d;
  logic                         last_beat;
  logic [BW-1:0]                lo_idx;
  logic [BW-1:0]                hi_idx;

  // Burst shape for the incoming request; refill wins when both alloc and unc are set.
  always_comb begin
    ar_addr_d = req_paddr_i & ~32'h3;
    ar_len_d  = 8'd0;
    if (req_alloc_i) begin
      ar_addr_d = req_paddr_i & ~32'hF;
      ar_len_d  = 8'(LINE_WORDS - 1);
    end else if (req_size_i == 2'd3) begin
      ar_addr_d = req_paddr_i & ~32'h7;
      ar_len_d  = 8'd1;
    end
  end

  // Round-robin victim way and its one-hot tag write enable.
  always_comb begin
    way_d = (way_q == WW'(WAYS - 1)) ? '0 : way_q + 1'b1;
    twe_d = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_q == WW'(w)) twe_d[w] = 1'b1;
    end
  end

  // A beat closes the burst on r_last or when the counter reaches the requested length.
  assign last_beat = mem_r_last_i || (8'(beat_q) == ar_len_q);

  // Request FSM; every handshake and write-enable output is a flop set on the transition into its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      size_q    <= '0;
      alloc_q   <= 1'b0;
      way_q     <= '0;
      beat_q    <= '0;
      line_q    <= '0;
      ar_vld_q  <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      r_rdy_q   <= 1'b0;
      resp_q    <= 1'b0;
      dwe_q     <= 1'b0;
      twe_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && (req_alloc_i || req_unc_i)) begin
            paddr_q   <= req_paddr_i[31:2];
            size_q    <= req_size_i;
            alloc_q   <= req_alloc_i;
            ar_addr_q <= ar_addr_d;
            ar_len_q  <= ar_len_d;
            ar_vld_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (mem_ar_ready_i) begin
            ar_vld_q <= 1'b0;
            r_rdy_q  <= 1'b1;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (mem_r_valid_i) begin
            line_q[beat_q] <= mem_r_data_i;
            beat_q         <= beat_q + 1'b1;
            if (last_beat) begin
              r_rdy_q <= 1'b0;
              resp_q  <= 1'b1;
              dwe_q   <= alloc_q;
              twe_q   <= alloc_q ? twe_d : '0;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          resp_q  <= 1'b0;
          dwe_q   <= 1'b0;
          twe_q   <= '0;
          if (alloc_q) way_q <= way_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Doubleword return: refill picks the half-line containing paddr, 64-bit uncached is words {1,0},
  // 32-bit uncached places word 0 in lane paddr[2] and zeroes the other lane.
  always_comb begin
    lo_idx = BW'({paddr_q[3], 1'b0});
    hi_idx = BW'({paddr_q[3], 1'b1});
    if (alloc_q) begin
      resp_rdata_o = {line_q[hi_idx], line_q[lo_idx]};
    end else if (size_q == 2'd3) begin
      resp_rdata_o = {line_q[1], line_q[0]};
    end else if (paddr_q[2]) begin
      resp_rdata_o = {line_q[0], 32'd0};
    end else begin
      resp_rdata_o = {32'd0, line_q[0]};
    end
  end

  assign resp_ready_o   = resp_q;
  assign mem_ar_valid_o = ar_vld_q;
  assign mem_ar_addr_o  = ar_addr_q;
  assign mem_ar_len_o   = ar_len_q;
  assign mem_ar_size_o  = 3'd2;
  assign mem_r_ready_o  = r_rdy_q;
  assign snoop_daddr_o  = {paddr_q[11:4], 4'd0};
  assign snoop_taddr_o  = {paddr_q[11:4], 4'd0};
  assign snoop_dway_o   = 2'(way_q);
  assign snoop_d_o      = line_q;
  assign snoop_dwe_o    = dwe_q;
  assign snoop_twe_o    = twe_q;
  // The valid bit follows the latched request type so the tag bus reads all-zero out of reset.
  assign snoop_t_o      = {paddr_q[31:12], alloc_q};
endmodule

// File: tb/tb_wired_icache_refill.sv
module tb_wired_icache_refill;
  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i;
  logic [31:0]   req_paddr_i;
  logic [1:0]    req_size_i;
  logic          req_alloc_i;
  logic          req_unc_i;
  logic          resp_ready_o;
  logic [63:0]   resp_rdata_o;
  logic          mem_ar_valid_o;
  logic          mem_ar_ready_i;
  logic [31:0]   mem_ar_addr_o;
  logic [7:0]    mem_ar_len_o;
  logic [2:0]    mem_ar_size_o;
  logic          mem_r_valid_i;
  logic          mem_r_ready_o;
  logic [31:0]   mem_r_data_i;
  logic          mem_r_last_i;
  logic [11:0]   snoop_daddr_o;
  logic [1:0]    snoop_dway_o;
  logic [127:0]  snoop_d_o;
  logic          snoop_dwe_o;
  logic [11:0]   snoop_taddr_o;
  logic [3:0]    snoop_twe_o;
  logic [20:0]   snoop_t_o;

  wired_icache_refill #(.WAYS(4), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_paddr_i(req_paddr_i), .req_size_i(req_size_i),
    .req_alloc_i(req_alloc_i), .req_unc_i(req_unc_i),
    .resp_ready_o(resp_ready_o), .resp_rdata_o(resp_rdata_o),
    .mem_ar_valid_o(mem_ar_valid_o), .mem_ar_ready_i(mem_ar_ready_i),
    .mem_ar_addr_o(mem_ar_addr_o), .mem_ar_len_o(mem_ar_len_o), .mem_ar_size_o(mem_ar_size_o),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_ready_o(mem_r_ready_o),
    .mem_r_data_i(mem_r_data_i), .mem_r_last_i(mem_r_last_i),
    .snoop_daddr_o(snoop_daddr_o), .snoop_dway_o(snoop_dway_o), .snoop_d_o(snoop_d_o),
    .snoop_dwe_o(snoop_dwe_o), .snoop_taddr_o(snoop_taddr_o), .snoop_twe_o(snoop_twe_o),
    .snoop_t_o(snoop_t_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_exp_t;

  typedef struct {
    logic [63:0]  rdata;
    bit           alloc;
    logic [3:0]   twe;
    logic [1:0]   way;
    logic [11:0]  daddr;
    logic [20:0]  t;
    logic [127:0] d;
  } resp_exp_t;

  ar_exp_t   ar_q[$];
  resp_exp_t resp_q[$];
  logic [31:0] beat_dat [4];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp_rdy"}, resp_ready_o, 0);
    chk({tag, "_rdata"}, resp_rdata_o, 0);
    chk({tag, "_ar_vld"}, mem_ar_valid_o, 0);
    chk({tag, "_ar_addr"}, mem_ar_addr_o, 0);
    chk({tag, "_ar_len"}, mem_ar_len_o, 0);
    chk({tag, "_ar_size"}, mem_ar_size_o, 3'd2);
    chk({tag, "_r_rdy"}, mem_r_ready_o, 0);
    chk({tag, "_dwe"}, snoop_dwe_o, 0);
    chk({tag, "_twe"}, snoop_twe_o, 0);
    chk({tag, "_d"}, snoop_d_o, 0);
    chk({tag, "_daddr"}, snoop_daddr_o, 0);
    chk({tag, "_taddr"}, snoop_taddr_o, 0);
    chk({tag, "_dway"}, snoop_dway_o, 0);
    chk({tag, "_t"}, snoop_t_o, 0);
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    ar_exp_t e;
    e.addr = a; e.len = l;
    ar_q.push_back(e);
  endtask

  task automatic push_resp(input logic [63:0] rd, input bit al, input logic [3:0] twe,
                           input logic [1:0] way, input logic [11:0] da, input logic [20:0] t);
    resp_exp_t e;
    e.rdata = rd; e.alloc = al; e.twe = twe; e.way = way; e.daddr = da; e.t = t;
    e.d = {beat_dat[3], beat_dat[2], beat_dat[1], beat_dat[0]};
    resp_q.push_back(e);
  endtask

  // Monitor: checks AR on the rising edge of ar_valid and the response on every ready pulse.
  initial begin
    logic prev_arv;
    ar_exp_t ea;
    resp_exp_t er;
    prev_arv = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ar_valid_o && !prev_arv) begin
        if (ar_q.size() == 0) begin
          chk("ar_unexpected", 1, 0);
        end else begin
          ea = ar_q.pop_front();
          chk("ar_addr", mem_ar_addr_o, ea.addr);
          chk("ar_len", mem_ar_len_o, ea.len);
          chk("ar_size", mem_ar_size_o, 3'd2);
        end
      end
      prev_arv = mem_ar_valid_o;
      if (resp_ready_o) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          er = resp_q.pop_front();
          chk("rdata", resp_rdata_o, er.rdata);
          chk("dwe", snoop_dwe_o, er.alloc);
          chk("twe", snoop_twe_o, er.twe);
          if (er.alloc) begin
            chk("dway", snoop_dway_o, er.way);
            chk("daddr", snoop_daddr_o, er.daddr);
            chk("taddr", snoop_taddr_o, er.daddr);
            chk("tag", snoop_t_o, er.t);
            chk("line", snoop_d_o, er.d);
          end
        end
      end
    end
  end

  // Driver: one request with its AR and R handshakes; rst_at >= 0 asserts reset instead of that beat.
  task automatic run_txn(input logic [31:0] pa, input logic [1:0] sz, input bit al, input bit un,
                         input int nb, input int ar_dly, input bit gap, input bit give_last,
                         input int rst_at);
    int cnt;
    int i;
    bit ph;
    logic [31:0] a0;
    @(negedge clk);
    req_paddr_i = pa; req_size_i = sz; req_alloc_i = al; req_unc_i = un; req_valid_i = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!mem_ar_valid_o && cnt < 20);
    if (!mem_ar_valid_o) begin
      chk("ar_timeout", 0, 1);
      req_valid_i = 1'b0;
      return;
    end
    a0 = mem_ar_addr_o;
    cnt = 1;
    repeat (ar_dly) begin
      @(negedge clk);
      if (mem_ar_valid_o) cnt++;
      chk("ar_stable", mem_ar_addr_o, a0);
    end
    chk("ar_hold_cycles", cnt, ar_dly + 1);
    mem_ar_ready_i = 1'b1;
    @(negedge clk);
    mem_ar_ready_i = 1'b0;
    chk("ar_drop", mem_ar_valid_o, 0);
    i = 0; ph = 1'b0; cnt = 0;
    while (i < nb && cnt < 40) begin
      if (rst_at == i) begin
        rst = 1'b1; mem_r_valid_i = 1'b0; mem_r_last_i = 1'b0; req_valid_i = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (gap && ph) begin
        mem_r_valid_i = 1'b0;
        mem_r_last_i  = 1'b0;
      end else begin
        mem_r_valid_i = 1'b1;
        mem_r_data_i  = beat_dat[i];
        mem_r_last_i  = give_last && (i == nb - 1);
        if (mem_r_ready_o) i++;
      end
      ph = !ph;
      @(negedge clk);
      cnt++;
    end
    mem_r_valid_i = 1'b0;
    mem_r_last_i  = 1'b0;
    cnt = 0;
    while (!resp_ready_o && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("resp_seen", resp_ready_o, 1);
    req_valid_i = 1'b0;
    chk("r_rdy_in_done", mem_r_ready_o, 0);
    @(negedge clk);
    chk("pulse_one_cycle", resp_ready_o, 0);
    chk("r_rdy_after", mem_r_ready_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid_i = 0; req_paddr_i = 0; req_size_i = 0; req_alloc_i = 0; req_unc_i = 0;
    mem_ar_ready_i = 0; mem_r_valid_i = 0; mem_r_data_i = 0; mem_r_last_i = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Refill 1: way 0, upper half-line returned.
    beat_dat = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    push_ar(32'h1C00_0340, 8'd3);
    push_resp(64'h0000_00A3_0000_00A2, 1, 4'b0001, 2'd0, 12'h340, 21'h038001);
    run_txn(32'h1C00_0348, 2'd2, 1, 0, 4, 0, 0, 1, -1);

    // Uncached 64-bit with AR delayed 3 cycles.
    beat_dat = '{32'h11, 32'h22, 32'h0, 32'h0};
    push_ar(32'h8000_0010, 8'd1);
    push_resp(64'h0000_0022_0000_0011, 0, 4'b0000, 2'd0, 12'h0, 21'h0);
    run_txn(32'h8000_0010, 2'd3, 0, 1, 2, 3, 0, 1, -1);

    // Refill 2: way 1, lower half-line.
    beat_dat = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    push_ar(32'h0000_1230, 8'd3);
    push_resp(64'h0000_00B1_0000_00B0, 1, 4'b0010, 2'd1, 12'h230, 21'h000003);
    run_txn(32'h0000_1230, 2'd2, 1, 0, 4, 1, 0, 1, -1);

    // Uncached 32-bit, upper lane.
    beat_dat = '{32'h55, 32'h0, 32'h0, 32'h0};
    push_ar(32'h8000_0014, 8'd0);
    push_resp(64'h0000_0055_0000_0000, 0, 4'b0000, 2'd0, 12'h0, 21'h0);
    run_txn(32'h8000_0014, 2'd2, 0, 1, 1, 0, 0, 1, -1);

    // Refill 3: way 2, top of address space.
    beat_dat = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    push_ar(32'hFFFF_FFF0, 8'd3);
    push_resp(64'h0000_00C3_0000_00C2, 1, 4'b0100, 2'd2, 12'hFF0, 21'h1FFFFF);
    run_txn(32'hFFFF_FFF8, 2'd2, 1, 0, 4, 0, 0, 1, -1);

    // Uncached 32-bit, lower lane.
    beat_dat = '{32'h55, 32'h0, 32'h0, 32'h0};
    push_ar(32'h8000_0010, 8'd0);
    push_resp(64'h0000_0000_0000_0055, 0, 4'b0000, 2'd0, 12'h0, 21'h0);
    run_txn(32'h8000_0010, 2'd2, 0, 1, 1, 0, 0, 1, -1);

    // Refill 4: way 3, gapped beats and no r_last.
    beat_dat = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    push_ar(32'h0040_0000, 8'd3);
    push_resp(64'h0000_00D1_0000_00D0, 1, 4'b1000, 2'd3, 12'h000, 21'h000801);
    run_txn(32'h0040_0000, 2'd2, 1, 0, 4, 0, 1, 0, -1);

    // Refill 5: counter wraps to way 0; alloc wins over unc.
    beat_dat = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    push_ar(32'h1234_5670, 8'd3);
    push_resp(64'h0000_00E1_0000_00E0, 1, 4'b0001, 2'd0, 12'h670, 21'h02468B);
    run_txn(32'h1234_5670, 2'd3, 1, 1, 4, 0, 0, 1, -1);

    // Reset while waiting for beat 2 of a refill.
    beat_dat = '{32'h70, 32'h71, 32'h72, 32'h73};
    push_ar(32'h0000_2000, 8'd3);
    run_txn(32'h0000_2000, 2'd2, 1, 0, 4, 0, 0, 1, 2);

    // Refill after reset starts again from way 0.
    beat_dat = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
    push_ar(32'h0000_0010, 8'd3);
    push_resp(64'h0000_00F3_0000_00F2, 1, 4'b0001, 2'd0, 12'h010, 21'h000001);
    run_txn(32'h0000_0018, 2'd2, 1, 0, 4, 0, 0, 1, -1);

    repeat (4) @(negedge clk);
    chk("ar_queue_drained", ar_q.size(), 0);
    chk("resp_queue_drained", resp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
